// File: rtl/spu_mem.sv
`default_nettype none
//==============================================================================
// Module   : spu_mem
// Purpose  : IM/DM responder for the spu core with host preload/readback port
//            and a start/stop run sequencer. Optional watchdog: SPU_MEM_WDOG_EN.
// Revision : 1.0
//==============================================================================
module spu_mem #(
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 16,
    parameter int          IM_DEPTH   = 256,
    parameter int          DM_DEPTH   = 256,
    parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_sel,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_wr,
    input  logic              host_rd,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              host_go,
    output logic              host_busy,
    output logic              host_done,
    output logic              host_timeout,
    output logic [15:0]       run_cycles,
    output logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] im_addr,
    input  logic              im_rd,
    output logic [DATA_W-1:0] im_r_data,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [DATA_W-1:0] dm_w_data,
    output logic [DATA_W-1:0] dm_r_data
);

    localparam int IM_AW = $clog2(IM_DEPTH);
    localparam int DM_AW = $clog2(DM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       run_cycles_q, run_cycles_d;
    logic              start_q, busy_q, done_q, host_rvalid_q;
    logic [DATA_W-1:0] host_rdata_q, im_r_data_q, dm_r_data_q;

    logic [DATA_W-1:0] im_mem_q [IM_DEPTH];
    logic [DATA_W-1:0] dm_mem_q [DM_DEPTH];

    logic [IM_AW-1:0]  w_host_im_idx, w_proc_im_idx;
    logic [DM_AW-1:0]  w_host_dm_idx, w_proc_dm_idx, w_dm_widx;
    logic [DATA_W-1:0] w_dm_wdata;
    logic              w_host_own, w_proc_own, w_im_we, w_dm_we, w_host_rd;
    logic              w_unused_bits;

    assign w_host_im_idx = host_addr[IM_AW-1:0];
    assign w_host_dm_idx = host_addr[DM_AW-1:0];
    assign w_proc_im_idx = im_addr[IM_AW-1:0];
    assign w_proc_dm_idx = dm_addr[DM_AW-1:0];

    // Ownership is exclusive by state, so DM needs only one write port
    assign w_host_own = rst && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_proc_own = rst && ((state_q == ST_START) || (state_q == ST_RUN));
    assign w_im_we    = w_host_own && host_wr && !host_sel;
    assign w_dm_we    = (w_host_own && host_wr && host_sel) || (w_proc_own && dm_wr);
    assign w_dm_widx  = w_proc_own ? w_proc_dm_idx : w_host_dm_idx;
    assign w_dm_wdata = w_proc_own ? dm_w_data : host_wdata;
    assign w_host_rd  = w_host_own && host_rd && !host_wr;

`ifdef SPU_MEM_WDOG_EN
    logic timeout_q, timeout_d;
    assign host_timeout  = timeout_q;
    assign w_unused_bits = ^{host_addr, im_addr, dm_addr};
`else
    assign host_timeout  = 1'b0;
    assign w_unused_bits = ^{host_addr, im_addr, dm_addr, WDOG_LIMIT};
`endif

    always_comb begin
        state_d      = state_q;
        run_cycles_d = run_cycles_q;
`ifdef SPU_MEM_WDOG_EN
        timeout_d    = timeout_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (host_go) begin
                    state_d      = ST_START;
                    run_cycles_d = 16'd0;
`ifdef SPU_MEM_WDOG_EN
                    timeout_d    = 1'b0;
`endif
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (run_cycles_q != 16'hFFFF) begin
                    run_cycles_d = run_cycles_q + 16'd1;
                end
                if (stop) begin
                    state_d = ST_DONE;
                end
`ifdef SPU_MEM_WDOG_EN
                // Limit is hit on the edge where the count reaches it; stop has priority
                else if (run_cycles_d == WDOG_LIMIT) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            run_cycles_q <= 16'd0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SPU_MEM_WDOG_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            run_cycles_q <= run_cycles_d;
            start_q      <= (state_d == ST_START);
            busy_q       <= (state_d == ST_START) || (state_d == ST_RUN);
            done_q       <= (state_d == ST_DONE);
`ifdef SPU_MEM_WDOG_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            im_r_data_q   <= '0;
            dm_r_data_q   <= '0;
        end else begin
            host_rvalid_q <= w_host_rd;
            if (w_host_rd) begin
                host_rdata_q <= host_sel ? dm_mem_q[w_host_dm_idx] : im_mem_q[w_host_im_idx];
            end
            if (w_proc_own && im_rd) begin
                im_r_data_q <= im_mem_q[w_proc_im_idx];
            end
            if (w_proc_own && dm_rd) begin
                dm_r_data_q <= dm_mem_q[w_proc_dm_idx];
            end
        end
    end

    // Storage is intentionally not reset so preloaded contents survive a reset
    always_ff @(posedge clk) begin
        if (w_im_we) begin
            im_mem_q[w_host_im_idx] <= host_wdata;
        end
        if (w_dm_we) begin
            dm_mem_q[w_dm_widx] <= w_dm_wdata;
        end
    end

    assign start       = start_q;
    assign host_busy   = busy_q;
    assign host_done   = done_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign im_r_data   = im_r_data_q;
    assign dm_r_data   = dm_r_data_q;
    assign run_cycles  = run_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_spu_mem.sv
`default_nettype none
//==============================================================================
// Module   : tb_spu_mem
// Purpose  : Self-checking bench for spu_mem against an array-based memory model.
// Revision : 1.0
//==============================================================================
module tb_spu_mem;

    localparam int          IMD  = 256;
    localparam int          DMD  = 128;
    localparam logic [15:0] WLIM = 16'd20;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_sel, host_wr, host_rd, host_go, stop;
    logic [7:0]  host_addr, im_addr, dm_addr;
    logic [15:0] host_wdata, dm_w_data;
    logic        im_rd, dm_rd, dm_wr;
    logic [15:0] host_rdata, im_r_data, dm_r_data, run_cycles;
    logic        host_rvalid, host_busy, host_done, host_timeout, start;

    int total = 0;
    int bad   = 0;

    logic [15:0] im_ref [IMD];
    logic [15:0] dm_ref [DMD];

    spu_mem #(
        .ADDR_W(8), .DATA_W(16), .IM_DEPTH(IMD), .DM_DEPTH(DMD), .WDOG_LIMIT(WLIM)
    ) dut (
        .clk(clk), .rst(rst),
        .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_wr(host_wr), .host_rd(host_rd), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .host_go(host_go), .host_busy(host_busy),
        .host_done(host_done), .host_timeout(host_timeout), .run_cycles(run_cycles),
        .start(start), .stop(stop),
        .im_addr(im_addr), .im_rd(im_rd), .im_r_data(im_r_data),
        .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
        .dm_w_data(dm_w_data), .dm_r_data(dm_r_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic sel, input logic [7:0] a, input logic [15:0] d);
        host_sel = sel; host_addr = a; host_wdata = d; host_wr = 1'b1;
        tick();
        host_wr = 1'b0;
        if (sel) dm_ref[int'(a) % DMD] = d;
        else     im_ref[int'(a) % IMD] = d;
    endtask

    task automatic host_read(input logic sel, input logic [7:0] a,
                             output logic v, output logic [15:0] d);
        host_sel = sel; host_addr = a; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        v = host_rvalid; d = host_rdata;
    endtask

    task automatic go_run();
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        tick();
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        total++;
        if ({start, host_rvalid, host_busy, host_done, host_timeout} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000",
                            {start, host_rvalid, host_busy, host_done, host_timeout});
        end
        total++;
        if ({host_rdata, im_r_data, dm_r_data, run_cycles} !== 64'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0",
                            {host_rdata, im_r_data, dm_r_data, run_cycles});
        end
        rst = 1'b1;
        tick();
        total++;
        if ({start, host_busy, host_done} !== 3'b0) begin
            bad++; $display("FAIL idle_after_reset got=%b exp=000", {start, host_busy, host_done});
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < IMD; i++) host_write(1'b0, 8'(i), 16'($urandom));
        for (int i = 0; i < DMD; i++) host_write(1'b1, 8'(i), 16'($urandom));
    endtask

    task automatic test_preload();
        logic v; logic [15:0] d;
        host_write(1'b0, 8'd0, 16'h1234);
        host_write(1'b1, 8'd5, 16'hBEEF);
        host_read(1'b0, 8'd0, v, d);
        total++;
        if (v !== 1'b1 || d !== 16'h1234) begin
            bad++; $display("FAIL preload_im0 got=%b/%h exp=1/1234", v, d);
        end
        tick();
        total++;
        if (host_rvalid !== 1'b0) begin
            bad++; $display("FAIL rvalid_pulse got=%b exp=0", host_rvalid);
        end
        host_read(1'b1, 8'd5, v, d);
        total++;
        if (v !== 1'b1 || d !== 16'hBEEF) begin
            bad++; $display("FAIL preload_dm5 got=%b/%h exp=1/beef", v, d);
        end
        // write and read together: write wins, no read response
        host_sel = 1'b1; host_addr = 8'd9; host_wdata = 16'h4242;
        host_wr = 1'b1; host_rd = 1'b1;
        tick();
        host_wr = 1'b0; host_rd = 1'b0;
        dm_ref[9] = 16'h4242;
        total++;
        if (host_rvalid !== 1'b0) begin
            bad++; $display("FAIL wr_rd_collide_rvalid got=%b exp=0", host_rvalid);
        end
        host_read(1'b1, 8'd9, v, d);
        total++;
        if (d !== dm_ref[9]) begin
            bad++; $display("FAIL wr_rd_collide_data got=%h exp=%h", d, dm_ref[9]);
        end
        // address above DM depth aliases onto low word
        host_write(1'b1, 8'd133, 16'h7777);
        host_read(1'b1, 8'd5, v, d);
        total++;
        if (d !== 16'h7777) begin
            bad++; $display("FAIL dm_alias got=%h exp=7777", d);
        end
    endtask

    task automatic test_run_handshake();
        logic start_extra = 1'b0;
        logic busy_drop   = 1'b0;
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        total++;
        if (start !== 1'b1 || host_busy !== 1'b1 || host_done !== 1'b0) begin
            bad++; $display("FAIL go_start got=%b%b%b exp=110", start, host_busy, host_done);
        end
        for (int i = 1; i <= 10; i++) begin
            host_go = (i == 4);
            tick();
            start_extra |= start;
            busy_drop   |= ~host_busy;
        end
        host_go = 1'b0;
        total++;
        if (start_extra !== 1'b0 || busy_drop !== 1'b0) begin
            bad++; $display("FAIL start_one_cycle got=%b%b exp=00", start_extra, busy_drop);
        end
        stop_run();
        total++;
        if (host_done !== 1'b1 || host_busy !== 1'b0 || run_cycles !== 16'd10) begin
            bad++; $display("FAIL stop_done got=%b%b/%0d exp=10/10", host_done, host_busy, run_cycles);
        end
        tick(); tick();
        total++;
        if (run_cycles !== 16'd10 || host_done !== 1'b1) begin
            bad++; $display("FAIL done_hold got=%0d/%b exp=10/1", run_cycles, host_done);
        end
    endtask

    task automatic test_proc_dm();
        logic v; logic [15:0] d;
        go_run();
        dm_addr = 8'd3; dm_w_data = 16'h00AA; dm_wr = 1'b1;
        tick();
        dm_wr = 1'b0; dm_ref[3] = 16'h00AA;
        dm_rd = 1'b1; im_rd = 1'b1; im_addr = 8'd0;
        tick();
        dm_rd = 1'b0; im_rd = 1'b0;
        total++;
        if (dm_r_data !== 16'h00AA) begin
            bad++; $display("FAIL proc_dm_rd got=%h exp=00aa", dm_r_data);
        end
        total++;
        if (im_r_data !== im_ref[0]) begin
            bad++; $display("FAIL proc_im_rd got=%h exp=%h", im_r_data, im_ref[0]);
        end
        stop_run();
        host_read(1'b1, 8'd3, v, d);
        total++;
        if (v !== 1'b1 || d !== 16'h00AA) begin
            bad++; $display("FAIL host_sees_proc_wr got=%b/%h exp=1/00aa", v, d);
        end
    endtask

    task automatic test_collisions();
        logic v; logic [15:0] d;
        go_run();
        dm_addr = 8'd7; dm_w_data = 16'h0001; dm_wr = 1'b1;
        tick();
        dm_w_data = 16'h0002; dm_rd = 1'b1;
        tick();
        dm_wr = 1'b0; dm_rd = 1'b0;
        dm_ref[7] = 16'h0002;
        total++;
        if (dm_r_data !== 16'h0001) begin
            bad++; $display("FAIL rd_before_wr got=%h exp=0001", dm_r_data);
        end
        dm_rd = 1'b1;
        tick();
        dm_rd = 1'b0;
        total++;
        if (dm_r_data !== 16'h0002) begin
            bad++; $display("FAIL rd_after_wr got=%h exp=0002", dm_r_data);
        end
        host_sel = 1'b1; host_addr = 8'd3; host_wdata = 16'hDEAD; host_wr = 1'b1;
        tick();
        host_wr = 1'b0; host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        tick();
        total++;
        if (host_rvalid !== 1'b0) begin
            bad++; $display("FAIL host_rd_in_run got=%b exp=0", host_rvalid);
        end
        stop_run();
        host_read(1'b1, 8'd3, v, d);
        total++;
        if (d !== dm_ref[3]) begin
            bad++; $display("FAIL host_wr_in_run_dropped got=%h exp=%h", d, dm_ref[3]);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_im, exp_dm, exp_hd;
        logic        exp_v;
        int          a;
        go_run();
        for (int i = 0; i < 60; i++) begin
            im_rd = (i == 0) ? 1'b1 : 1'($urandom);
            dm_rd = (i == 0) ? 1'b1 : 1'($urandom);
            dm_wr = 1'($urandom);
            im_addr = 8'($urandom); dm_addr = 8'($urandom); dm_w_data = 16'($urandom);
            if (im_rd) exp_im = im_ref[int'(im_addr)];
            a = int'(dm_addr) % DMD;
            if (dm_rd) exp_dm = dm_ref[a];
            if (dm_wr) dm_ref[a] = dm_w_data;
            tick();
            total++;
            if (im_r_data !== exp_im || dm_r_data !== exp_dm) begin
                bad++; $display("FAIL rand_proc[%0d] got=%h/%h exp=%h/%h",
                                i, im_r_data, dm_r_data, exp_im, exp_dm);
            end
        end
        im_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
        stop_run();
        for (int i = 0; i < 60; i++) begin
            host_sel = 1'($urandom); host_addr = 8'($urandom); host_wdata = 16'($urandom);
            host_wr = ($urandom % 3) == 0; host_rd = 1'($urandom);
            im_rd = 1'($urandom); dm_rd = 1'($urandom); dm_wr = 1'($urandom);
            im_addr = 8'($urandom); dm_addr = 8'($urandom); dm_w_data = 16'($urandom);
            exp_v = host_rd && !host_wr;
            exp_hd = host_sel ? dm_ref[int'(host_addr) % DMD] : im_ref[int'(host_addr)];
            if (host_wr && host_sel)  dm_ref[int'(host_addr) % DMD] = host_wdata;
            if (host_wr && !host_sel) im_ref[int'(host_addr)] = host_wdata;
            tick();
            total++;
            if (host_rvalid !== exp_v || (exp_v && host_rdata !== exp_hd)) begin
                bad++; $display("FAIL rand_host[%0d] got=%b/%h exp=%b/%h",
                                i, host_rvalid, host_rdata, exp_v, exp_hd);
            end
            total++;
            if (im_r_data !== exp_im || dm_r_data !== exp_dm) begin
                bad++; $display("FAIL rand_proc_hold[%0d] got=%h/%h exp=%h/%h",
                                i, im_r_data, dm_r_data, exp_im, exp_dm);
            end
        end
        host_wr = 1'b0; host_rd = 1'b0; im_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic v; logic [15:0] d;
        logic start_seen = 1'b0;
        go_run();
        dm_addr = 8'd20; dm_w_data = 16'h5A5A; dm_wr = 1'b1; dm_rd = 1'b1;
        im_addr = 8'd1; im_rd = 1'b1;
        tick();
        dm_wr = 1'b0; dm_rd = 1'b0; im_rd = 1'b0;
        dm_ref[20] = 16'h5A5A;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({start, host_rvalid, host_busy, host_done, host_timeout} !== 5'b0 ||
            {host_rdata, im_r_data, dm_r_data, run_cycles} !== 64'h0) begin
            bad++; $display("FAIL reset_mid_run got=%b/%h exp=0/0",
                            {start, host_rvalid, host_busy, host_done, host_timeout},
                            {host_rdata, im_r_data, dm_r_data, run_cycles});
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            start_seen |= start | host_busy;
        end
        total++;
        if (start_seen !== 1'b0) begin
            bad++; $display("FAIL no_restart got=%b exp=0", start_seen);
        end
        host_read(1'b1, 8'd20, v, d);
        total++;
        if (v !== 1'b1 || d !== 16'h5A5A) begin
            bad++; $display("FAIL dm_survives_reset got=%b/%h exp=1/5a5a", v, d);
        end
    endtask

    task automatic test_watchdog();
        int n;
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        total++;
        if (host_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_clear got=%b exp=0", host_timeout);
        end
        n = 0;
        while (!host_done && n < 100) begin
            tick();
            n++;
        end
`ifdef SPU_MEM_WDOG_EN
        total++;
        if (host_done !== 1'b1 || host_timeout !== 1'b1 || run_cycles !== WLIM || n != 21) begin
            bad++; $display("FAIL wdog_fire got=%b%b/%0d/%0d exp=11/20/21",
                            host_done, host_timeout, run_cycles, n);
        end
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        total++;
        if (host_timeout !== 1'b0) begin
            bad++; $display("FAIL wdog_clear got=%b exp=0", host_timeout);
        end
        for (int i = 0; i < 20; i++) tick();
        stop_run();
        total++;
        if (host_done !== 1'b1 || host_timeout !== 1'b0 || run_cycles !== WLIM) begin
            bad++; $display("FAIL stop_beats_wdog got=%b%b/%0d exp=10/20",
                            host_done, host_timeout, run_cycles);
        end
`else
        total++;
        if (host_done !== 1'b0 || host_timeout !== 1'b0 || host_busy !== 1'b1) begin
            bad++; $display("FAIL no_wdog got=%b%b%b exp=001", host_done, host_timeout, host_busy);
        end
        stop_run();
        total++;
        if (host_done !== 1'b1 || run_cycles !== 16'(n)) begin
            bad++; $display("FAIL no_wdog_stop got=%b/%0d exp=1/%0d", host_done, run_cycles, n);
        end
`endif
    endtask

    initial begin
        rst = 1'b0; host_sel = 1'b0; host_addr = '0; host_wdata = '0;
        host_wr = 1'b0; host_rd = 1'b0; host_go = 1'b0; stop = 1'b0;
        im_addr = '0; im_rd = 1'b0; dm_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0; dm_w_data = '0;
        test_reset();
        test_fill();
        test_preload();
        test_run_handshake();
        test_proc_dm();
        test_collisions();
        test_random();
        test_reset_mid_run();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spu_mem.md
# spu_mem

Memory-side responder and run controller for the `spu` processor top. Holds the 256×16 instruction memory (IM) and 256×16 data memory (DM), and answers the processor's `im_*`/`dm_*` requests with a one-cycle registered read. Exposes a host port to preload IM/DM and read back DM. Sequences a run by pulsing `start` and waiting for `stop`.

## Interface
- `ADDR_W`, 8, address width of both memories
- `DATA_W`, 16, word width of both memories
- `IM_DEPTH`, 256, IM words (power of 2, ≤ 2^ADDR_W)
- `DM_DEPTH`, 256, DM words (power of 2, ≤ 2^ADDR_W)
- `WDOG_LIMIT`, 16'hFFFF, run-cycle limit; used only with `SPU_MEM_WDOG_EN`
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `host_sel`  in  1  0 = host access targets IM, 1 = DM
- `host_addr`  in  ADDR_W  host word address
- `host_wdata`  in  DATA_W  host write data
- `host_wr`  in  1  host write strobe
- `host_rd`  in  1  host read strobe
- `host_rdata`  out  DATA_W  host read data
- `host_rvalid`  out  1  one-cycle pulse, `host_rdata` valid
- `host_go`  in  1  request a processor run
- `host_busy`  out  1  run in progress (START/RUN)
- `host_done`  out  1  last run finished (DONE state)
- `host_timeout`  out  1  last run ended by watchdog
- `run_cycles`  out  16  cycles spent in RUN for the last/current run, saturating
- `start`  out  1  to processor `start`
- `stop`  in  1  from processor `stop`
- `im_addr`  in  ADDR_W  processor IM address
- `im_rd`  in  1  processor IM read enable
- `im_r_data`  out  DATA_W  IM read data to processor
- `dm_addr`  in  ADDR_W  processor DM address
- `dm_rd`, `dm_wr`  in  1  processor DM read/write enables
- `dm_w_data`  in  DATA_W  processor DM write data
- `dm_r_data`  out  DATA_W  DM read data to processor

## Operation
- FSM states: IDLE, START, RUN, DONE. After reset the FSM is in IDLE.
- IDLE → START on `host_go`.
- START: `start`=1 for exactly one cycle. `stop` is ignored. Always → RUN.
- RUN → DONE when `stop`=1 is sampled. `start`=0.
- DONE → START on `host_go`.
- Host port owns the memories in IDLE and DONE:
  - `host_wr` writes `host_wdata` to the selected memory at `host_addr`.
  - `host_rd` returns data the next cycle with `host_rvalid`=1.
  - If `host_wr` and `host_rd` are asserted together, the write wins and no `host_rvalid` is produced.
- In START/RUN, host accesses are dropped: no write, no `host_rvalid`. `host_go` is ignored.
- Processor port is served only in START/RUN:
  - `im_rd`/`dm_rd` load the read register from the addressed word.
  - `dm_wr` writes `dm_w_data`.
  - `dm_rd` with `dm_wr` to the same address returns the old word (read-before-write).
  - Outside START/RUN, processor strobes are ignored and the read registers hold.
- `im_r_data`/`dm_r_data` hold their last value until the next accepted read.
- Addresses index modulo depth: only the low log2(DEPTH) bits are used.
- `run_cycles`:
  - Cleared to 0 on entry to START.
  - +1 each RUN cycle, saturating at 16'hFFFF.
  - Held in IDLE/DONE.
- `host_timeout` is cleared on entry to START.

## Timing
- Reset (`rst`=0 at a rising edge):
  - FSM → IDLE.
  - `start`, `host_rvalid`, `host_busy`, `host_done`, `host_timeout` = 0.
  - `host_rdata`, `im_r_data`, `dm_r_data`, `run_cycles` = 0.
  - Memory contents are not cleared.
  - Reset during RUN aborts the run; `start` is never re-issued.
- Read latency is 1 cycle on both ports. Data is registered; there is no combinational path from address to data.
- Writes take effect at the same edge; a read of that address in the next cycle returns the new data.
- `host_busy` = (state is START or RUN). `host_done` = (state is DONE). Both are registered state decodes.
- `host_go` pulse → `start` high the following cycle.
- `stop` sampled high in RUN → `host_done`=1 the following cycle.

## Configuration
- `SPU_MEM_WDOG_EN` defined:
  - In RUN, when `run_cycles` reaches `WDOG_LIMIT` without `stop`, the FSM goes to DONE with `host_timeout`=1.
  - If `stop` arrives in the same cycle as the limit, `stop` wins and `host_timeout`=0.
- `SPU_MEM_WDOG_EN` undefined:
  - No watchdog; RUN waits for `stop` indefinitely.
  - `host_timeout` is tied to 0.

## Test plan
- Preload: host writes IM[0]=16'h1234 and DM[5]=16'hBEEF, then host reads both → `host_rdata` is 16'h1234, then 16'hBEEF, each one cycle after `host_rd` with a one-cycle `host_rvalid`.
- Run handshake: `host_go` in IDLE → `start` high exactly one cycle and `host_busy`=1. Model `stop` high 10 cycles after START → `host_done`=1 and `run_cycles`=10.
- Processor DM access in RUN: `dm_wr` of 16'h00AA to addr 3, then `dm_rd` of addr 3 → `dm_r_data`=16'h00AA after 1 cycle. After DONE, a host read of DM[3] returns 16'h00AA.
- Collisions:
  - Host write during RUN → memory unchanged, no `host_rvalid`.
  - Same-cycle `dm_rd`+`dm_wr` to addr 7 (old 16'h0001, new 16'h0002) → `dm_r_data`=16'h0001.
- Reset mid-RUN: drive `rst`=0 → next cycle state is IDLE, all outputs 0, and DM contents written before reset are still readable by the host.
- Watchdog (`SPU_MEM_WDOG_EN`, `WDOG_LIMIT`=20): hold `stop`=0 → DONE with `host_timeout`=1 and `run_cycles`=20. Without the macro, no DONE is reached within 100 cycles.
